fetch_redirect_ctrl: RTL and testbench
======================================

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameter DS_TIMEOUT, default 15: maximum cycles spent waiting for a delay-slot bundle before forcing the redirect.
REQ-002 Parameter CNT_W, default 32: width of the redirect statistics counters.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port be_redirect_i, input, 1: backend redirect request (mispredict or exception); highest priority.
REQ-006 Port be_redirect_pc_i, input, 32: backend target PC.
REQ-007 Port if3_redirect_i, input, 1: IF3 predecode redirect request.
REQ-008 Port if3_redirect_pc_i, input, 32: IF3 target PC.
REQ-009 Port if3_rescue_ds_i, input, 1: the IF3 branch sits in slot 1, so its delay slot is not yet fetched.
REQ-010 Port fetch_ready_i, input, 1: IF1 accepts a new PC this cycle.
REQ-011 Port ds_fetched_i, input, 1: the bundle following the branch has entered IF3.
REQ-012 Port pc_redirect_o, output, 1: PC redirect valid to IF1.
REQ-013 Port pc_redirect_pc_o, output, 32: redirect target.
REQ-014 Port flush_if12_o, output, 1: kill IF1/IF2 contents.
REQ-015 Port flush_if3_o, output, 1: kill IF3 contents.
REQ-016 Port busy_o, output, 1: state is not IDLE.
REQ-017 Port be_cnt_o, output, CNT_W: count of accepted backend redirects.
REQ-018 Port if3_cnt_o, output, CNT_W: count of accepted IF3 redirects.

Function
REQ-019 States: IDLE, WAIT_DS, PEND; FSM, target register and counters all registered.
REQ-020 Request capture: requests are sampled at the clock edge; pc_redirect_o asserts in the following cycle (1-cycle latency) and holds until a cycle with fetch_ready_i=1, then deasserts next cycle.
REQ-021 IDLE with be_redirect_i=1: capture be_redirect_pc_i, go to PEND, pulse flush_if12_o and flush_if3_o for one cycle.
REQ-022 IDLE with if3_redirect_i=1, if3_rescue_ds_i=0 and no backend request: capture if3_redirect_pc_i, go to PEND, pulse flush_if12_o only.
REQ-023 IDLE with if3_redirect_i=1 and if3_rescue_ds_i=1: capture the target, clear the wait counter, go to WAIT_DS, no flush.
REQ-024 WAIT_DS: increment the wait counter each cycle; on ds_fetched_i=1, or when the counter reaches DS_TIMEOUT, go to PEND and pulse flush_if12_o.
REQ-025 PEND: drive pc_redirect_o=1 with the held target; return to IDLE on the edge where fetch_ready_i=1.
REQ-026 be_redirect_i in any state preempts: overwrite the target, go to PEND, pulse both flushes, abandon any WAIT_DS; the same-cycle IF3 request is dropped.
REQ-027 if3_redirect_i while in WAIT_DS or PEND is ignored and not counted.
REQ-028 Simultaneous fetch_ready_i=1 in PEND and a new backend request: the backend wins; stay in PEND with the new target.
REQ-029 pc_redirect_o is never asserted in IDLE or WAIT_DS.
REQ-030 Counters increment by 1 per accepted request and wrap modulo 2^CNT_W.
REQ-031 Outputs depend only on registered state; there is no combinational input-to-output path.

Reset
REQ-032 On rst, go to IDLE asynchronously and clear all outputs to 0: pc_redirect_o, pc_redirect_pc_o=32'h0, flushes, busy_o and both counters.
REQ-033 Reset asserted mid-WAIT_DS or mid-PEND discards the pending target; no redirect is issued after release.

Structure
REQ-034 The state enum and the default DS_TIMEOUT constant are placed in the shared defs package.
REQ-035 The wait counter plus timeout compare is one natural sub-module, named ds_wait_timer.

Verification
REQ-036 IF3 redirect to 32'h8000_0100 (rescue=0), fetch_ready_i=1: next cycle pc_redirect_o=1 with that target and flush_if12_o=1, flush_if3_o=0; IDLE one cycle later; if3_cnt_o=1.
REQ-037 IF3 redirect with rescue=1, ds_fetched_i asserted 3 cycles later: no redirect during WAIT_DS; then PEND with a flush_if12_o pulse and the captured target.
REQ-038 Rescue request with ds_fetched_i held at 0: forced to PEND after exactly 15 wait cycles.
REQ-039 In WAIT_DS, backend redirect to 32'hBFC0_0380: PEND with target 32'hBFC0_0380, both flushes pulse; be_cnt_o=1.
REQ-040 Same-cycle backend and IF3 requests: backend target taken, if3_cnt_o unchanged.
REQ-041 PEND with fetch_ready_i=0 for 4 cycles: pc_redirect_o and target held stable; rst asserted mid-PEND: all outputs 0 immediately.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// fetch_redirect_ctrl_pkg
// Shared definitions for the fetch redirect controller.
//   - redirect_state_e   : controller state encoding
//   - DS_TIMEOUT_DEFAULT : default number of cycles to wait for a delay-slot
//                          bundle before the redirect is forced
package fetch_redirect_ctrl_pkg;

  localparam int DS_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    PEND    = 2'd2
  } redirect_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_ds_wait_timer.sv
// ds_wait_timer
// Counts the cycles spent waiting for a delay-slot bundle and flags the cycle
// in which the count reaches TIMEOUT.
// Ports:
//   clk       : clock
//   rst       : asynchronous active-high reset
//   i_clear   : force the count to zero
//   i_enable  : advance the count by one
//   o_expired : this cycle's increment brings the count to TIMEOUT
module ds_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  // The count starts at zero on entry to the wait, so the first wait cycle sees
  // zero. Flagging at TIMEOUT-1 makes the controller leave after exactly
  // TIMEOUT wait cycles.
  assign o_expired = (r_count == W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// Arbitrates backend and IF3 predecode redirects into a single registered PC
// redirect toward IF1. A redirect is held until IF1 accepts it. IF3 branches
// whose delay slot has not yet been fetched wait in WAIT_DS until the slot
// arrives or the wait times out.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   be_redirect_i/_pc_i : backend redirect request and target (highest priority)
//   if3_redirect_i/_pc_i: IF3 predecode redirect request and target
//   if3_rescue_ds_i     : IF3 branch needs its delay slot fetched first
//   fetch_ready_i       : IF1 accepts a new PC this cycle
//   ds_fetched_i        : delay-slot bundle has reached IF3
//   pc_redirect_o/_pc_o : redirect valid and target toward IF1
//   flush_if12_o        : kill IF1/IF2 contents
//   flush_if3_o         : kill IF3 contents
//   busy_o              : controller not idle
//   be_cnt_o, if3_cnt_o : accepted backend / IF3 redirect counts
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int DS_TIMEOUT = DS_TIMEOUT_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             be_redirect_i,
  input  logic [31:0]      be_redirect_pc_i,
  input  logic             if3_redirect_i,
  input  logic [31:0]      if3_redirect_pc_i,
  input  logic             if3_rescue_ds_i,
  input  logic             fetch_ready_i,
  input  logic             ds_fetched_i,
  output logic             pc_redirect_o,
  output logic [31:0]      pc_redirect_pc_o,
  output logic             flush_if12_o,
  output logic             flush_if3_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] be_cnt_o,
  output logic [CNT_W-1:0] if3_cnt_o
);

  redirect_state_e r_state;
  logic            r_pcRedirect;
  logic [31:0]     r_target;
  logic            r_flushIf12;
  logic            r_flushIf3;
  logic            r_busy;
  logic [CNT_W-1:0] r_beCnt;
  logic [CNT_W-1:0] r_if3Cnt;

  logic w_inWaitDs;
  logic w_timerExpired;

  assign w_inWaitDs = (r_state == WAIT_DS);

  // Holding the timer clear outside WAIT_DS guarantees every wait starts at zero.
  ds_wait_timer #(
    .TIMEOUT (DS_TIMEOUT)
  ) u_ds_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_inWaitDs),
    .i_enable  (w_inWaitDs),
    .o_expired (w_timerExpired)
  );

  // Single-process FSM. Every output is registered and written alongside the
  // state change that implies it. Flushes are one-cycle pulses, so they default
  // low. A backend request preempts whatever the FSM is doing, including a
  // same-cycle IF3 request and a same-cycle IF1 acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pcRedirect <= 1'b0;
      r_target     <= 32'h0;
      r_flushIf12  <= 1'b0;
      r_flushIf3   <= 1'b0;
      r_busy       <= 1'b0;
      r_beCnt      <= '0;
      r_if3Cnt     <= '0;
    end else begin
      r_flushIf12 <= 1'b0;
      r_flushIf3  <= 1'b0;
      if (be_redirect_i) begin
        r_state      <= PEND;
        r_target     <= be_redirect_pc_i;
        r_pcRedirect <= 1'b1;
        r_busy       <= 1'b1;
        r_flushIf12  <= 1'b1;
        r_flushIf3   <= 1'b1;
        r_beCnt      <= r_beCnt + CNT_W'(1);
      end else begin
        case (r_state)
          IDLE: begin
            if (if3_redirect_i) begin
              r_target <= if3_redirect_pc_i;
              r_busy   <= 1'b1;
              r_if3Cnt <= r_if3Cnt + CNT_W'(1);
              if (if3_rescue_ds_i) begin
                r_state <= WAIT_DS;
              end else begin
                r_state      <= PEND;
                r_pcRedirect <= 1'b1;
                r_flushIf12  <= 1'b1;
              end
            end
          end
          WAIT_DS: begin
            if (ds_fetched_i || w_timerExpired) begin
              r_state      <= PEND;
              r_pcRedirect <= 1'b1;
              r_flushIf12  <= 1'b1;
            end
          end
          PEND: begin
            if (fetch_ready_i) begin
              r_state      <= IDLE;
              r_pcRedirect <= 1'b0;
              r_busy       <= 1'b0;
            end
          end
          default: begin
            r_state      <= IDLE;
            r_pcRedirect <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc_redirect_o    = r_pcRedirect;
  assign pc_redirect_pc_o = r_target;
  assign flush_if12_o     = r_flushIf12;
  assign flush_if3_o      = r_flushIf3;
  assign busy_o           = r_busy;
  assign be_cnt_o         = r_beCnt;
  assign if3_cnt_o        = r_if3Cnt;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl
// Directed bench for fetch_redirect_ctrl. Inputs change 1 time unit after the
// rising edge, and outputs are sampled at the same point, so every check sees
// the state registered by the edge just taken.
module tb_fetch_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        beRedirect;
  logic [31:0] beRedirectPc;
  logic        if3Redirect;
  logic [31:0] if3RedirectPc;
  logic        if3RescueDs;
  logic        fetchReady;
  logic        dsFetched;
  logic        pcRedirect;
  logic [31:0] pcRedirectPc;
  logic        flushIf12;
  logic        flushIf3;
  logic        busy;
  logic [31:0] beCnt;
  logic [31:0] if3Cnt;

  int checkCount;
  int errorCount;

  fetch_redirect_ctrl #(
    .DS_TIMEOUT (15),
    .CNT_W      (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .be_redirect_i     (beRedirect),
    .be_redirect_pc_i  (beRedirectPc),
    .if3_redirect_i    (if3Redirect),
    .if3_redirect_pc_i (if3RedirectPc),
    .if3_rescue_ds_i   (if3RescueDs),
    .fetch_ready_i     (fetchReady),
    .ds_fetched_i      (dsFetched),
    .pc_redirect_o     (pcRedirect),
    .pc_redirect_pc_o  (pcRedirectPc),
    .flush_if12_o      (flushIf12),
    .flush_if3_o       (flushIf3),
    .busy_o            (busy),
    .be_cnt_o          (beCnt),
    .if3_cnt_o         (if3Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive every DUT input at once.
  task automatic applyStimulus(input logic be, input logic [31:0] bePc,
                               input logic if3, input logic [31:0] if3Pc,
                               input logic rescue, input logic ready,
                               input logic ds);
    beRedirect    = be;
    beRedirectPc  = bePc;
    if3Redirect   = if3;
    if3RedirectPc = if3Pc;
    if3RescueDs   = rescue;
    fetchReady    = ready;
    dsFetched     = ds;
  endtask

  // Advance past one rising edge, landing at the sampling point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_pc_redirect", {31'h0, pcRedirect}, 32'h0);
    checkOutput("reset_target", pcRedirectPc, 32'h0);
    checkOutput("reset_flush_if12", {31'h0, flushIf12}, 32'h0);
    checkOutput("reset_flush_if3", {31'h0, flushIf3}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_be_cnt", beCnt, 32'h0);
    checkOutput("reset_if3_cnt", if3Cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // IF3 redirect without delay-slot rescue, IF1 ready throughout.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("if3_pc_redirect", {31'h0, pcRedirect}, 32'h1);
    checkOutput("if3_target", pcRedirectPc, 32'h8000_0100);
    checkOutput("if3_flush_if12", {31'h0, flushIf12}, 32'h1);
    checkOutput("if3_flush_if3", {31'h0, flushIf3}, 32'h0);
    checkOutput("if3_cnt", if3Cnt, 32'h1);
    step();
    checkOutput("if3_idle_redirect", {31'h0, pcRedirect}, 32'h0);
    checkOutput("if3_idle_busy", {31'h0, busy}, 32'h0);
    checkOutput("if3_idle_flush", {31'h0, flushIf12}, 32'h0);

    // IF3 redirect with rescue; delay slot arrives on the third wait cycle.
    // A second IF3 request during the wait must be ignored.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0200, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0AAA, 1'b0, 1'b1, 1'b0);
    checkOutput("rescue_busy", {31'h0, busy}, 32'h1);
    checkOutput("rescue_no_redirect0", {31'h0, pcRedirect}, 32'h0);
    checkOutput("rescue_no_flush", {31'h0, flushIf12}, 32'h0);
    checkOutput("rescue_cnt", if3Cnt, 32'h2);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("rescue_no_redirect1", {31'h0, pcRedirect}, 32'h0);
    checkOutput("rescue_ignored_cnt", if3Cnt, 32'h2);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("rescue_no_redirect2", {31'h0, pcRedirect}, 32'h0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("rescue_pend_redirect", {31'h0, pcRedirect}, 32'h1);
    checkOutput("rescue_pend_target", pcRedirectPc, 32'h8000_0200);
    checkOutput("rescue_pend_flush_if12", {31'h0, flushIf12}, 32'h1);
    checkOutput("rescue_pend_flush_if3", {31'h0, flushIf3}, 32'h0);
    step();
    checkOutput("rescue_done_redirect", {31'h0, pcRedirect}, 32'h0);
    checkOutput("rescue_done_busy", {31'h0, busy}, 32'h0);

    // Rescue with no delay slot: forced to PEND after exactly 15 wait cycles.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0300, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      checkOutput($sformatf("timeout_wait%0d", i), {31'h0, pcRedirect}, 32'h0);
      step();
    end
    checkOutput("timeout_wait14", {31'h0, pcRedirect}, 32'h0);
    step();
    checkOutput("timeout_redirect", {31'h0, pcRedirect}, 32'h1);
    checkOutput("timeout_flush_if12", {31'h0, flushIf12}, 32'h1);
    checkOutput("timeout_target", pcRedirectPc, 32'h8000_0300);

    // Hold PEND with IF1 stalled for four cycles, then reset mid-PEND.
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("hold_redirect%0d", i), {31'h0, pcRedirect}, 32'h1);
      checkOutput($sformatf("hold_target%0d", i), pcRedirectPc, 32'h8000_0300);
      checkOutput($sformatf("hold_flush%0d", i), {31'h0, flushIf12}, 32'h0);
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_redirect", {31'h0, pcRedirect}, 32'h0);
    checkOutput("midreset_target", pcRedirectPc, 32'h0);
    checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
    checkOutput("midreset_if3_cnt", if3Cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    step();
    checkOutput("postreset_redirect", {31'h0, pcRedirect}, 32'h0);
    checkOutput("postreset_busy", {31'h0, busy}, 32'h0);

    // Backend redirect preempts a delay-slot wait.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0400, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'hBFC0_0380, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("preempt_wait_if3_cnt", if3Cnt, 32'h1);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("preempt_redirect", {31'h0, pcRedirect}, 32'h1);
    checkOutput("preempt_target", pcRedirectPc, 32'hBFC0_0380);
    checkOutput("preempt_flush_if12", {31'h0, flushIf12}, 32'h1);
    checkOutput("preempt_flush_if3", {31'h0, flushIf3}, 32'h1);
    checkOutput("preempt_be_cnt", beCnt, 32'h1);
    step();
    checkOutput("preempt_done", {31'h0, pcRedirect}, 32'h0);
    checkOutput("preempt_flush_clear", {31'h0, flushIf3}, 32'h0);

    // Same-cycle backend and IF3 requests: backend wins, IF3 not counted.
    applyStimulus(1'b1, 32'hBFC0_0200, 1'b1, 32'h8000_0500, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("both_target", pcRedirectPc, 32'hBFC0_0200);
    checkOutput("both_if3_cnt", if3Cnt, 32'h1);
    checkOutput("both_be_cnt", beCnt, 32'h2);
    checkOutput("both_flush_if3", {31'h0, flushIf3}, 32'h1);

    // Backend request on the same edge IF1 accepts: stay in PEND, new target.
    applyStimulus(1'b1, 32'hBFC0_0180, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("accept_race_redirect", {31'h0, pcRedirect}, 32'h1);
    checkOutput("accept_race_target", pcRedirectPc, 32'hBFC0_0180);
    checkOutput("accept_race_busy", {31'h0, busy}, 32'h1);
    checkOutput("accept_race_be_cnt", beCnt, 32'h3);
    step();
    checkOutput("final_redirect", {31'h0, pcRedirect}, 32'h0);
    checkOutput("final_busy", {31'h0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
